// File: rtl/vga_frame_monitor_if.sv
// VGA stream from the generator as seen by the frame monitor.
// The generator side drives the bundle; the monitor side only observes it.
interface vga_frame_monitor_if;
    logic       HS;
    logic       VS;
    logic [3:0] RED;
    logic [3:0] GREEN;
    logic [3:0] BLUE;

    modport master (output HS, VS, RED, GREEN, BLUE);
    modport slave  (input  HS, VS, RED, GREEN, BLUE);
endinterface

// File: rtl/vga_frame_monitor.sv
// VGA frame monitor: recovers pixel coordinates from HS/VS timing, checks line/frame timing
// and reports a per-frame checksum plus count and bounding box of TARGET_RGB pixels.
module vga_frame_monitor #(
    parameter int          CLKS_PER_PIXEL = 4,
    parameter int          SAMPLE_PHASE   = 2,
    parameter int          H_START        = 144,
    parameter int          H_ACTIVE       = 640,
    parameter int          H_TOTAL        = 800,
    parameter int          V_START        = 35,
    parameter int          V_ACTIVE       = 480,
    parameter bit          SYNC_POL       = 1'b0,
    parameter logic [11:0] TARGET_RGB     = 12'hF00
) (
    input  logic               clk,
    input  logic               clk_reset,
    vga_frame_monitor_if.slave vga,
    output logic               pix_valid,
    output logic [9:0]         pix_x,
    output logic [9:0]         pix_y,
    output logic [11:0]        pix_rgb,
    output logic               frame_done,
    output logic [15:0]        frame_checksum,
    output logic [18:0]        frame_target_n,
    output logic [9:0]         frame_min_x,
    output logic [9:0]         frame_min_y,
    output logic [9:0]         frame_max_x,
    output logic [9:0]         frame_max_y,
    output logic               locked,
    output logic               sync_error
);

    localparam int              PW           = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
    localparam logic [PW-1:0]   PHASE_LAST   = PW'(CLKS_PER_PIXEL - 1);
    localparam logic [PW-1:0]   PHASE_SAMPLE = PW'(SAMPLE_PHASE);
    localparam logic [10:0]     H_FIRST      = 11'(H_START);
    localparam logic [10:0]     H_END        = 11'(H_START + H_ACTIVE);
    localparam logic [10:0]     H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0]     V_FIRST      = 11'(V_START);
    localparam logic [10:0]     V_END        = 11'(V_START + V_ACTIVE);
    localparam logic [10:0]     CNT_MAX      = 11'h7FF;
    localparam logic [18:0]     TN_MAX       = 19'h7FFFF;
    localparam logic [9:0]      COORD_MAX    = 10'h3FF;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        BLANK    = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            hs_r1;
    logic            hs_r2;
    logic            vs_r1;
    logic            vs_r2;
    logic [11:0]     rgb_r1;
    logic [11:0]     rgb_r2;

    logic            hs_edge;
    logic            vs_edge;

    logic [PW-1:0]   phase;
    logic [10:0]     h_cnt;
    logic [10:0]     v_cnt;
    logic [10:0]     v_cnt_nxt;

    logic            line_err;
    logic            frame_err;
    logic            any_err;
    logic            frame_end;

    logic            sample_cycle;
    logic            frame_commit;
    logic            acc_clear;

    logic [15:0]     cks;
    logic [18:0]     tn;
    logic [9:0]      min_x;
    logic [9:0]      min_y;
    logic [9:0]      max_x;
    logic [9:0]      max_y;

    logic [15:0]     cks_upd;
    logic [18:0]     tn_upd;
    logic [9:0]      min_x_upd;
    logic [9:0]      min_y_upd;
    logic [9:0]      max_x_upd;
    logic [9:0]      max_y_upd;

    // Two register stages: r1 against r2 gives the assert edge, r2 RGB lines up with the pixel counters.
    always_ff @(posedge clk) begin
        if (clk_reset) begin
            hs_r1  <= 1'b0;
            hs_r2  <= 1'b0;
            vs_r1  <= 1'b0;
            vs_r2  <= 1'b0;
            rgb_r1 <= 12'h000;
            rgb_r2 <= 12'h000;
        end else begin
            hs_r1  <= vga.HS;
            hs_r2  <= hs_r1;
            vs_r1  <= vga.VS;
            vs_r2  <= vs_r1;
            rgb_r1 <= {vga.RED, vga.GREEN, vga.BLUE};
            rgb_r2 <= rgb_r1;
        end
    end

    assign hs_edge = (hs_r1 == SYNC_POL) && (hs_r2 != SYNC_POL);
    assign vs_edge = (vs_r1 == SYNC_POL) && (vs_r2 != SYNC_POL);

    always_comb begin
        v_cnt_nxt = v_cnt;
        if (vs_edge) begin
            v_cnt_nxt = 11'd0;
        end else if (hs_edge && (v_cnt != CNT_MAX)) begin
            v_cnt_nxt = v_cnt + 11'd1;
        end
    end

    // Counters saturate so a lost sync can never wrap around into a false match.
    always_ff @(posedge clk) begin
        if (clk_reset) begin
            phase <= '0;
            h_cnt <= 11'd0;
            v_cnt <= 11'd0;
        end else begin
            v_cnt <= v_cnt_nxt;
            if (hs_edge) begin
                phase <= '0;
                h_cnt <= 11'd0;
            end else if (phase == PHASE_LAST) begin
                phase <= '0;
                if (h_cnt != CNT_MAX) begin
                    h_cnt <= h_cnt + 11'd1;
                end
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

    // Any VS edge while ACTIVE is early by construction; in BLANK only the top-of-frame lines are early.
    assign line_err  = hs_edge && (state != UNLOCKED) && (h_cnt != H_LAST);
    assign frame_err = vs_edge && (state != UNLOCKED) && (v_cnt < V_END);
    assign any_err   = line_err || frame_err;
    assign frame_end = (state == ACTIVE) && hs_edge && (v_cnt_nxt == V_END) && !any_err;

    always_ff @(posedge clk) begin
        if (clk_reset) begin
            state <= UNLOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            UNLOCKED: if (vs_edge) state_nxt = BLANK;
            BLANK:    if (hs_edge && (v_cnt_nxt == V_FIRST)) state_nxt = ACTIVE;
            ACTIVE:   if (frame_end) state_nxt = BLANK;
            default:  state_nxt = UNLOCKED;
        endcase
        if (any_err) begin
            state_nxt = vs_edge ? BLANK : UNLOCKED;
        end
    end

    always_comb begin
        sample_cycle = 1'b0;
        frame_commit = 1'b0;
        acc_clear    = 1'b0;
        if ((state == ACTIVE) && (phase == PHASE_SAMPLE) && (h_cnt >= H_FIRST) &&
            (h_cnt < H_END) && !any_err) begin
            sample_cycle = 1'b1;
        end
        if (frame_end) begin
            frame_commit = 1'b1;
            acc_clear    = 1'b1;
        end
        if (vs_edge && ((state == UNLOCKED) || any_err)) begin
            acc_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_reset) begin
            pix_valid <= 1'b0;
            pix_x     <= 10'd0;
            pix_y     <= 10'd0;
            pix_rgb   <= 12'h000;
        end else begin
            pix_valid <= sample_cycle;
            if (sample_cycle) begin
                pix_x   <= 10'(h_cnt - H_FIRST);
                pix_y   <= 10'(v_cnt - V_FIRST);
                pix_rgb <= rgb_r2;
            end
        end
    end

    always_comb begin
        cks_upd   = cks;
        tn_upd    = tn;
        min_x_upd = min_x;
        min_y_upd = min_y;
        max_x_upd = max_x;
        max_y_upd = max_y;
        if (pix_valid) begin
            cks_upd = {cks[14:0], cks[15]} ^ {4'h0, pix_rgb};
            if (pix_rgb == TARGET_RGB) begin
                if (tn != TN_MAX) tn_upd = tn + 19'd1;
                if (pix_x < min_x) min_x_upd = pix_x;
                if (pix_y < min_y) min_y_upd = pix_y;
                if (pix_x > max_x) max_x_upd = pix_x;
                if (pix_y > max_y) max_y_upd = pix_y;
            end
        end
    end

    // A pixel landing in the commit cycle still belongs to the finished frame, hence the _upd values.
    always_ff @(posedge clk) begin
        if (clk_reset) begin
            cks   <= 16'h0000;
            tn    <= 19'd0;
            min_x <= 10'd0;
            min_y <= 10'd0;
            max_x <= 10'd0;
            max_y <= 10'd0;
        end else if (acc_clear) begin
            cks   <= 16'h0000;
            tn    <= 19'd0;
            min_x <= COORD_MAX;
            min_y <= COORD_MAX;
            max_x <= 10'd0;
            max_y <= 10'd0;
        end else begin
            cks   <= cks_upd;
            tn    <= tn_upd;
            min_x <= min_x_upd;
            min_y <= min_y_upd;
            max_x <= max_x_upd;
            max_y <= max_y_upd;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_reset) begin
            frame_done     <= 1'b0;
            frame_checksum <= 16'h0000;
            frame_target_n <= 19'd0;
            frame_min_x    <= 10'd0;
            frame_min_y    <= 10'd0;
            frame_max_x    <= 10'd0;
            frame_max_y    <= 10'd0;
        end else begin
            frame_done <= frame_commit;
            if (frame_commit) begin
                frame_checksum <= cks_upd;
                frame_target_n <= tn_upd;
                frame_min_x    <= min_x_upd;
                frame_min_y    <= min_y_upd;
                frame_max_x    <= max_x_upd;
                frame_max_y    <= max_y_upd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clk_reset) begin
            locked     <= 1'b0;
            sync_error <= 1'b0;
        end else if (any_err) begin
            locked     <= 1'b0;
            sync_error <= 1'b1;
        end else if (frame_commit) begin
            locked     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a shrunken 16x10-pixel raster (8x6 visible)
// so a whole frame is only 640 clocks.
module tb_vga_frame_monitor;

    localparam int          CPP         = 4;
    localparam int          SAMPLE_PH   = 2;
    localparam int          H_ST        = 4;
    localparam int          H_ACT       = 8;
    localparam int          H_TOT       = 16;
    localparam int          V_ST        = 2;
    localparam int          V_ACT       = 6;
    localparam int          V_TOT       = 10;
    localparam int          HSYNC_PX    = 2;
    localparam int          VSYNC_LINES = 2;
    localparam int          FRAME_CLKS  = H_TOT * V_TOT * CPP;
    localparam logic [11:0] TGT         = 12'hF00;

    logic        clk = 1'b0;
    logic        clk_reset;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [11:0] pix_rgb;
    logic        frame_done;
    logic [15:0] frame_checksum;
    logic [18:0] frame_target_n;
    logic [9:0]  frame_min_x;
    logic [9:0]  frame_min_y;
    logic [9:0]  frame_max_x;
    logic [9:0]  frame_max_y;
    logic        locked;
    logic        sync_error;

    vga_frame_monitor_if vga ();

    vga_frame_monitor #(
        .CLKS_PER_PIXEL (CPP),
        .SAMPLE_PHASE   (SAMPLE_PH),
        .H_START        (H_ST),
        .H_ACTIVE       (H_ACT),
        .H_TOTAL        (H_TOT),
        .V_START        (V_ST),
        .V_ACTIVE       (V_ACT),
        .SYNC_POL       (1'b0),
        .TARGET_RGB     (TGT)
    ) dut (
        .clk            (clk),
        .clk_reset      (clk_reset),
        .vga            (vga),
        .pix_valid      (pix_valid),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_rgb        (pix_rgb),
        .frame_done     (frame_done),
        .frame_checksum (frame_checksum),
        .frame_target_n (frame_target_n),
        .frame_min_x    (frame_min_x),
        .frame_min_y    (frame_min_y),
        .frame_max_x    (frame_max_x),
        .frame_max_y    (frame_max_y),
        .locked         (locked),
        .sync_error     (sync_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cur_mode = 0;

    int pv_frame = 0;
    int pv_at_done = 0;
    int first_x = -1;
    int first_y = -1;
    int last_x = -1;
    int last_y = -1;
    bit have_prev = 0;
    int prev_cyc = 0;
    int prev_y = 0;
    int gap_err = 0;
    int rgb_err = 0;
    int done_count = 0;
    int done_cyc_prev = 0;
    int done_period = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // mode 0: black with 3x2 target block at (2,1); mode 1: all black;
    // mode 2: gradient with target pixels only in the two extreme corners
    function automatic logic [11:0] pix_color(input int mode, input int x, input int y);
        logic [11:0] c;
        c = 12'h000;
        if (mode == 0) begin
            if (x >= 2 && x <= 4 && y >= 1 && y <= 2) c = TGT;
        end else if (mode == 2) begin
            if ((x == 0 && y == 0) || (x == H_ACT - 1 && y == V_ACT - 1)) c = TGT;
            else c = 12'((x << 8) | (y << 4) | 10);
        end
        return c;
    endfunction

    function automatic logic [15:0] model_checksum(input int mode);
        logic [15:0] c;
        c = 16'h0000;
        for (int y = 0; y < V_ACT; y++)
            for (int x = 0; x < H_ACT; x++)
                c = {c[14:0], c[15]} ^ {4'h0, pix_color(mode, x, y)};
        return c;
    endfunction

    always @(negedge clk) begin
        if (clk_reset) have_prev = 0;
        if (pix_valid) begin
            if (pv_frame == 0) begin
                first_x = int'(pix_x);
                first_y = int'(pix_y);
            end
            last_x = int'(pix_x);
            last_y = int'(pix_y);
            if (have_prev && prev_y == int'(pix_y) && (cyc - prev_cyc) != CPP) gap_err++;
            have_prev = 1;
            prev_cyc  = cyc;
            prev_y    = int'(pix_y);
            if (pix_rgb !== pix_color(cur_mode, int'(pix_x), int'(pix_y))) rgb_err++;
            pv_frame++;
        end
        if (frame_done) begin
            done_count++;
            done_period   = cyc - done_cyc_prev;
            done_cyc_prev = cyc;
            pv_at_done    = pv_frame;
            pv_frame      = 0;
            have_prev     = 0;
        end
    end

    // One frame of generator output; short_line loses 4 pixels, abort_line ends the frame early,
    // reset_line pulses clk_reset for one clock at the start of that line.
    task automatic apply_stimulus(input int mode, input int short_line, input int abort_line, input int reset_line);
        int          len;
        bit          vis;
        logic [11:0] rgb;
        cur_mode = mode;
        for (int ln = 0; ln < V_TOT; ln++) begin
            if (ln == abort_line) return;
            len = (ln == short_line) ? H_TOT - 4 : H_TOT;
            for (int p = 0; p < len; p++) begin
                for (int ph = 0; ph < CPP; ph++) begin
                    @(negedge clk);
                    if (ln == reset_line && p == 0 && ph == 1) begin
                        check_output("rst_mid_locked", locked, 1'b0);
                        check_output("rst_mid_sync_error", sync_error, 1'b0);
                        check_output("rst_mid_target_n", frame_target_n, 19'd0);
                        check_output("rst_mid_checksum", frame_checksum, 16'h0000);
                        check_output("rst_mid_others",
                                     {pix_valid, frame_done, |pix_x, |pix_y, |pix_rgb,
                                      |frame_min_x, |frame_min_y, |frame_max_x, |frame_max_y}, 9'd0);
                    end
                    clk_reset = (ln == reset_line && p == 0 && ph == 0);
                    vis = (ln >= V_ST) && (ln < V_ST + V_ACT) && (p >= H_ST) && (p < H_ST + H_ACT);
                    rgb = vis ? pix_color(mode, p - H_ST, ln - V_ST) : 12'h000;
                    vga.HS    = (p < HSYNC_PX) ? 1'b0 : 1'b1;
                    vga.VS    = (ln < VSYNC_LINES) ? 1'b0 : 1'b1;
                    vga.RED   = rgb[11:8];
                    vga.GREEN = rgb[7:4];
                    vga.BLUE  = rgb[3:0];
                end
            end
        end
    endtask

    task automatic check_block_frame(input string tag);
        check_output({tag, "_target_n"}, frame_target_n, 19'd6);
        check_output({tag, "_min_x"}, frame_min_x, 10'd2);
        check_output({tag, "_min_y"}, frame_min_y, 10'd1);
        check_output({tag, "_max_x"}, frame_max_x, 10'd4);
        check_output({tag, "_max_y"}, frame_max_y, 10'd2);
        check_output({tag, "_checksum"}, frame_checksum, 16'h6969);
    endtask

    initial begin
        int dc;
        clk_reset = 1'b1;
        vga.HS    = 1'b1;
        vga.VS    = 1'b1;
        vga.RED   = 4'h0;
        vga.GREEN = 4'h0;
        vga.BLUE  = 4'h0;
        repeat (3) @(negedge clk);
        check_output("rst_locked", locked, 1'b0);
        check_output("rst_sync_error", sync_error, 1'b0);
        check_output("rst_frame_done", frame_done, 1'b0);
        check_output("rst_pix_valid", pix_valid, 1'b0);
        check_output("rst_min_x", frame_min_x, 10'd0);
        clk_reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] ideal frames with target block");
        apply_stimulus(0, -1, -1, -1);
        check_output("f1_done_count", done_count, 1);
        check_block_frame("f1");
        check_output("f1_locked", locked, 1'b1);
        check_output("f1_sync_error", sync_error, 1'b0);
        check_output("f1_pulses", pv_at_done, H_ACT * V_ACT);
        check_output("f1_first_x", first_x, 0);
        check_output("f1_first_y", first_y, 0);
        check_output("f1_last_x", last_x, H_ACT - 1);
        check_output("f1_last_y", last_y, V_ACT - 1);
        apply_stimulus(0, -1, -1, -1);
        check_output("f2_done_count", done_count, 2);
        check_output("f2_period", done_period, FRAME_CLKS);
        check_output("f2_pulses", pv_at_done, H_ACT * V_ACT);

        $display("[TB] all-black frame");
        apply_stimulus(1, -1, -1, -1);
        check_output("black_target_n", frame_target_n, 19'd0);
        check_output("black_min_x", frame_min_x, 10'h3FF);
        check_output("black_min_y", frame_min_y, 10'h3FF);
        check_output("black_max_x", frame_max_x, 10'd0);
        check_output("black_max_y", frame_max_y, 10'd0);
        check_output("black_checksum", frame_checksum, 16'h0000);

        $display("[TB] gradient frame with corner targets");
        apply_stimulus(2, -1, -1, -1);
        check_output("grad_checksum", frame_checksum, model_checksum(2));
        check_output("grad_target_n", frame_target_n, 19'd2);
        check_output("grad_min_x", frame_min_x, 10'd0);
        check_output("grad_min_y", frame_min_y, 10'd0);
        check_output("grad_max_x", frame_max_x, 10'd7);
        check_output("grad_max_y", frame_max_y, 10'd5);

        $display("[TB] short line");
        dc = done_count;
        apply_stimulus(0, 4, -1, -1);
        check_output("short_no_done", done_count, dc);
        check_output("short_sync_error", sync_error, 1'b1);
        check_output("short_locked", locked, 1'b0);
        apply_stimulus(0, -1, -1, -1);
        check_output("short_resume_done", done_count, dc + 1);
        check_block_frame("short_resume");
        check_output("short_sticky_error", sync_error, 1'b1);
        check_output("short_relocked", locked, 1'b1);

        $display("[TB] reset mid-frame");
        dc = done_count;
        apply_stimulus(2, -1, -1, 5);
        check_output("rst_no_done", done_count, dc);
        apply_stimulus(0, -1, -1, -1);
        check_output("rst_resume_done", done_count, dc + 1);
        check_output("rst_resume_sync_error", sync_error, 1'b0);
        check_output("rst_resume_locked", locked, 1'b1);
        check_block_frame("rst_resume");

        $display("[TB] early VS inside active region");
        dc = done_count;
        apply_stimulus(2, -1, 4, -1);
        check_output("early_vs_no_done", done_count, dc);
        apply_stimulus(0, -1, -1, -1);
        check_output("early_vs_done", done_count, dc + 1);
        check_output("early_vs_sync_error", sync_error, 1'b1);
        check_output("early_vs_locked", locked, 1'b1);
        check_block_frame("early_vs");

        check_output("pixel_spacing_errors", gap_err, 0);
        check_output("pixel_rgb_errors", rgb_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
